// File: rtl/serial_comp_ctrl.sv
// Bit-serial unsigned magnitude comparator (MSB first) behind a valid/ready handshake.
// Optional macro SERIAL_COMP_EARLY_EXIT_EN ends the compare at the first differing bit.
module serial_comp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             lt,
  output logic             eq,
  output logic             busy
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  // Result held one-hot as {gt, lt, eq}; all-zero means not yet decided.
  logic [2:0]       res_q, res_d;

  logic bit_a, bit_b, differ, last_bit, decided, cmp_end;

  assign bit_a    = a_q[idx_q];
  assign bit_b    = b_q[idx_q];
  assign differ   = bit_a ^ bit_b;
  assign last_bit = (idx_q == '0);
  assign decided  = |res_q;

`ifdef SERIAL_COMP_EARLY_EXIT_EN
  assign cmp_end = last_bit | differ;
`else
  assign cmp_end = last_bit;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = CMP;
      CMP:     if (cmp_end)   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    idx_d = idx_q;
    res_d = res_q;
    if (state_q == IDLE && in_valid) begin
      a_d   = a;
      b_d   = b;
      idx_d = IW'(WIDTH - 1);
      res_d = '0;
    end else if (state_q == CMP) begin
      // idx saturates at 0 so the last CMP cycle never wraps back to the MSB
      if (!last_bit) idx_d = idx_q - IW'(1);
      if (!decided) begin
        if (differ)        res_d = bit_a ? 3'b100 : 3'b010;
        else if (last_bit) res_d = 3'b001;
      end
    end
  end

  always_comb begin
    in_ready     = (state_q == IDLE);
    busy         = (state_q != IDLE);
    out_valid    = (state_q == DONE);
    {gt, lt, eq} = out_valid ? res_q : 3'b000;
  end

endmodule

// File: tb/tb_serial_comp_ctrl.sv
// Randomised-stall bench for serial_comp_ctrl (WIDTH=4) against an arithmetic reference model.
// Honours SERIAL_COMP_EARLY_EXIT_EN when computing expected latency.
module tb_serial_comp_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic         gt, lt, eq, busy;

  int n_cmp = 0;
  int n_bad = 0;

  serial_comp_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gt        (gt),
    .lt        (lt),
    .eq        (eq),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: result as {gt,lt,eq} from plain magnitude comparison.
  function automatic int ref_res(input int x, input int y);
    if (x > y) return 4;
    if (x < y) return 2;
    return 1;
  endfunction

  // Reference latency in cycles from the accept cycle to the first out_valid cycle.
  function automatic int ref_lat(input int x, input int y);
    int d, p;
    d = x ^ y;
`ifdef SERIAL_COMP_EARLY_EXIT_EN
    if (d == 0) return W + 1;
    p = 0;
    for (int k = 0; k < W; k++) if ((d >> k) & 1) p = k;
    return (W - 1 - p) + 2;
`else
    p = d;
    return W + 1;
`endif
  endfunction

  task automatic run_op(input int x, input int y, input int stall);
    int cnt, lat, res, er;
    a = W'(x); b = W'(y); in_valid = 1'b1; out_ready = 1'b0;
    cnt = 0;
    while (!in_ready && cnt < 50) begin @(negedge clk); cnt++; end
    chk("accept_timeout", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk("flags_idle", int'({gt, lt, eq}), 0);
      @(negedge clk);
      lat++;
    end
    res = int'({gt, lt, eq});
    er  = ref_res(x, y);
    $display("op a=%0d b=%0d res=%0b exp=%0b lat=%0d exp_lat=%0d stall=%0d",
             x, y, res, er, lat, ref_lat(x, y), stall);
    chk("out_valid", int'(out_valid), 1);
    chk("result", res, er);
    chk("latency", lat, ref_lat(x, y));
    // Offer conflicting new data while stalled; nothing may change.
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1; a = ~W'(x); b = ~W'(y);
      @(negedge clk);
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_res", int'({gt, lt, eq}), er);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid", int'(out_valid), 0);
    chk("release_in_ready", int'(in_ready), 1);
    chk("release_flags", int'({gt, lt, eq}), 0);
  endtask

  initial begin
    int cnt, seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_flags", int'({gt, lt, eq}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed boundary cases.
    run_op(8, 7, 0);
    run_op(10, 10, 0);
    run_op(2, 3, 0);
    run_op(3, 2, 0);
    run_op(0, 15, 1);
    run_op(15, 15, 3);

    // Reset in the second CMP cycle discards the operation.
    a = 4'hF; b = 4'h0; in_valid = 1'b1;
    cnt = 0;
    while (!in_ready && cnt < 50) begin @(negedge clk); cnt++; end
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_busy_cmp1", int'(busy), 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_busy", int'(busy), 0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk("abort_no_valid", seen, 0);
    $display("abort a=15 b=0 out_valid_pulses=%0d", seen);
    run_op(1, 1, 0);

    // Exhaustive pairs with random consumer stalls.
    for (int i = 0; i < 256; i++) begin
      run_op(i >> 4, i & 15, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "timeout");
  end
endmodule
